// File: rtl/sdram_wr_burst_feeder.sv
// Write-burst feeder: buffers a 16-bit word stream and drains it to the SDRAM
// controller as fixed-length bursts at wrapping addresses. WR_FEEDER_STATS_EN adds burst_cnt.
module sdram_wr_burst_feeder #(
  parameter int MEM_DATA_BITS = 16,
  parameter int ADDR_BITS     = 24,
  parameter int BURST_BITS    = 10,
  parameter int BURST_SIZE    = 128,
  parameter int FIFO_DEPTH    = 256,
  parameter int BASE_ADDR     = 0,
  parameter int REGION_WORDS  = 1 << 20
) (
  input  logic                         mem_clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [MEM_DATA_BITS-1:0]     in_data,
  output logic                         in_ready,
  input  logic                         flush,
  output logic                         wr_burst_req,
  output logic [BURST_BITS-1:0]        wr_burst_len,
  output logic [ADDR_BITS-1:0]         wr_burst_addr,
  input  logic                         wr_burst_data_req,
  output logic [MEM_DATA_BITS-1:0]     wr_burst_data,
  input  logic                         wr_burst_finish,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                         busy
`ifdef WR_FEEDER_STATS_EN
  ,
  output logic [31:0]                  burst_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (ADDR_BITS + 1 > LW) ? ADDR_BITS + 1 : LW;
  localparam logic [CW-1:0]        REGION_END = CW'(BASE_ADDR + REGION_WORDS);
  localparam logic [CW-1:0]        BURST_W    = CW'(BURST_SIZE);
  localparam logic [LW-1:0]        DEPTH_L    = LW'(FIFO_DEPTH);
  localparam logic [ADDR_BITS-1:0] BASE       = ADDR_BITS'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, BURST, UPDATE} state_t;
  state_t state, state_next;

  logic [MEM_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [LW-1:0]            level;
  logic [BURST_BITS-1:0]    sent;
  logic                     flush_pend;
  logic                     push, pop, launch, flush_clr;
  logic [CW-1:0]            level_w, room, cand, launch_len, addr_sum;

  assign in_ready     = level < DEPTH_L;
  assign push         = in_valid && in_ready;
  assign pop          = (state == BURST) && wr_burst_data_req && (sent < wr_burst_len);
  assign fifo_level   = level;
  assign wr_burst_req = (state == BURST);
  assign busy         = (state != IDLE) || flush_pend;
  assign addr_sum     = CW'(wr_burst_addr) + CW'(wr_burst_len);

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Launch length: full burst or the flushed remainder, never past region end.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    flush_clr  = 1'b0;
    level_w    = CW'(level);
    room       = REGION_END - CW'(wr_burst_addr);
    cand       = (level_w >= BURST_W) ? BURST_W : level_w;
    launch_len = (cand < room) ? cand : room;
    case (state)
      IDLE: begin
        if (level_w >= BURST_W || (flush_pend && level_w != '0)) begin
          launch     = 1'b1;
          state_next = BURST;
        end
        flush_clr = (launch && launch_len == level_w) || (level_w == '0);
      end
      BURST:   if (wr_burst_finish) state_next = UPDATE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      sent          <= '0;
      flush_pend    <= 1'b0;
      wr_burst_len  <= '0;
      wr_burst_addr <= BASE;
      wr_burst_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        wr_burst_data <= mem[rd_ptr];
        sent          <= sent + 1'b1;
      end
      if (push != pop) level <= push ? level + 1'b1 : level - 1'b1;
      flush_pend <= flush || (flush_pend && !flush_clr);
      if (launch) begin
        wr_burst_len <= BURST_BITS'(launch_len);
        sent         <= '0;
      end
      if (state == UPDATE)
        wr_burst_addr <= (addr_sum >= REGION_END) ? BASE : ADDR_BITS'(addr_sum);
    end
  end

`ifdef WR_FEEDER_STATS_EN
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst)                  burst_cnt <= '0;
    else if (state == UPDATE) burst_cnt <= burst_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_sdram_wr_burst_feeder.sv
// Bench for sdram_wr_burst_feeder: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, and a simple SDRAM controller model.
module tb_sdram_wr_burst_feeder;

  localparam int DEPTH = 256;
  localparam int BS    = 128;
  localparam int RW    = 256;
  localparam int BASE  = 0;
  localparam int ENDA  = BASE + RW;

  logic        mem_clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        wr_burst_req;
  logic [9:0]  wr_burst_len;
  logic [23:0] wr_burst_addr;
  logic        wr_burst_data_req = 1'b0;
  logic [15:0] wr_burst_data;
  logic        wr_burst_finish = 1'b0;
  logic [8:0]  fifo_level;
  logic        busy;
`ifdef WR_FEEDER_STATS_EN
  logic [31:0] burst_cnt;
`endif

  sdram_wr_burst_feeder #(.REGION_WORDS(RW)) dut (
    .mem_clk(mem_clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .flush(flush),
    .wr_burst_req(wr_burst_req),
    .wr_burst_len(wr_burst_len),
    .wr_burst_addr(wr_burst_addr),
    .wr_burst_data_req(wr_burst_data_req),
    .wr_burst_data(wr_burst_data),
    .wr_burst_finish(wr_burst_finish),
    .fifo_level(fifo_level),
    .busy(busy)
`ifdef WR_FEEDER_STATS_EN
    ,
    .burst_cnt(burst_cnt)
`endif
  );

  always #5 mem_clk = ~mem_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: buffered words, burst in flight, pending address update.
  int mq[$];
  int src[$];
  int m_addr, m_len, m_sent, m_data, m_cnt, n_both;
  bit m_inb, m_upd, m_fp;
  bit in_ready_s, prev_req;
  int rise_len[$];
  int rise_addr[$];

  bit stall, ctrl_rand, src_rand, flush_req, c_fin;
  int ctrl_extra, c_issued, c_extra;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_addr = BASE; m_len = 0; m_sent = 0; m_data = 0; m_cnt = 0;
    m_inb = 0; m_upd = 0; m_fp = 0;
  endtask

  task automatic model_step();
    int lvl;
    int n;
    bit acc, pop, idle, launch, clr;
    lvl    = mq.size();
    acc    = in_valid && (lvl < DEPTH);
    pop    = m_inb && wr_burst_data_req && (m_sent < m_len);
    idle   = !m_inb && !m_upd;
    launch = 0;
    n      = 0;
    if (idle && (lvl >= BS || (m_fp && lvl > 0))) begin
      n = (lvl >= BS) ? BS : lvl;
      if (n > ENDA - m_addr) n = ENDA - m_addr;
      launch = 1;
    end
    clr  = (launch && n == lvl) || (idle && lvl == 0);
    m_fp = flush ? 1'b1 : (m_fp && !clr);
    if (acc && pop) n_both++;
    if (pop) begin
      m_data = mq.pop_front();
      m_sent++;
    end
    if (acc) mq.push_back(int'(in_data));
    if (in_valid && in_ready_s && src.size() > 0) void'(src.pop_front());
    if (m_upd) begin
      m_addr = m_addr + m_len;
      if (m_addr >= ENDA) m_addr = BASE;
      m_cnt++;
      m_upd = 0;
    end else if (m_inb && wr_burst_finish) begin
      m_inb = 0;
      m_upd = 1;
    end else if (launch) begin
      m_inb  = 1;
      m_len  = n;
      m_sent = 0;
    end
  endtask

  task automatic compare();
    check("req", wr_burst_req, m_inb);
    if (m_inb) check("len", wr_burst_len, m_len);
    check("addr", wr_burst_addr, m_addr);
    check("data", wr_burst_data, m_data);
    check("level", fifo_level, mq.size());
    check("in_ready", in_ready, mq.size() < DEPTH);
    check("busy", busy, m_inb || m_upd || m_fp);
`ifdef WR_FEEDER_STATS_EN
    check("burst_cnt", burst_cnt, m_cnt);
`endif
    in_ready_s = in_ready;
    if (wr_burst_req && !prev_req) begin
      rise_len.push_back(int'(wr_burst_len));
      rise_addr.push_back(int'(wr_burst_addr));
    end
    prev_req = wr_burst_req;
  endtask

  task automatic drive();
    wr_burst_data_req = 1'b0;
    wr_burst_finish   = 1'b0;
    if (rst) begin
      in_valid = 1'b0; in_data = '0; flush = 1'b0;
      c_issued = 0; c_extra = 0; c_fin = 0;
      return;
    end
    in_valid  = (src.size() > 0) && (!src_rand || $urandom_range(0, 1) == 1);
    in_data   = (src.size() > 0) ? 16'(src[0]) : '0;
    flush     = flush_req;
    flush_req = 1'b0;
    if (wr_burst_req && !stall) begin
      if (c_issued < int'(wr_burst_len)) begin
        if (!ctrl_rand || $urandom_range(0, 1) == 1) begin
          wr_burst_data_req = 1'b1;
          c_issued++;
        end
      end else if (c_extra < ctrl_extra) begin
        wr_burst_data_req = 1'b1;
        c_extra++;
      end else if (!c_fin) begin
        wr_burst_finish = 1'b1;
        c_fin = 1;
      end
    end else if (!wr_burst_req) begin
      c_issued = 0; c_extra = 0; c_fin = 0;
    end
  endtask

  task automatic tick();
    @(posedge mem_clk);
    if (rst) model_reset();
    else     model_step();
    #1;
    compare();
    drive();
  endtask

  task automatic run_until_quiet(input int limit, input string name);
    bit done;
    done = 0;
    for (int i = 0; i < limit && !done; i++) begin
      tick();
      done = src.size() == 0 && !flush_req && !flush && !in_valid &&
             !m_inb && !m_upd && !m_fp && mq.size() < BS;
    end
    check({name, "_quiet"}, done, 1);
  endtask

  task automatic clear_log();
    rise_len.delete();
    rise_addr.delete();
  endtask

  task automatic check_bursts(input string name, input int n, input int len0, input int addr0);
    check({name, "_nbursts"}, rise_len.size(), n);
    if (rise_len.size() > 0) begin
      check({name, "_len0"}, rise_len[0], len0);
      check({name, "_addr0"}, rise_addr[0], addr0);
    end
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit hit;
    model_reset();
    stall = 0; ctrl_rand = 0; src_rand = 0; ctrl_extra = 0; flush_req = 0;
    n_both = 0; prev_req = 0; in_ready_s = 1;
    repeat (3) tick();
    check("rst_req", wr_burst_req, 0);
    check("rst_len", wr_burst_len, 0);
    check("rst_addr", wr_burst_addr, BASE);
    check("rst_data", wr_burst_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // One full burst of 0..127
    clear_log();
    for (int i = 0; i < 128; i++) src.push_back(i);
    run_until_quiet(600, "t1");
    check_bursts("t1", 1, 128, 0);
    check("t1_last_data", wr_burst_data, 127);
    check("t1_addr_after", wr_burst_addr, 128);
    check("t1_level_after", fifo_level, 0);

    // Region wrap: 128 then 0
    clear_log();
    for (int i = 0; i < 256; i++) src.push_back(256 + i);
    run_until_quiet(1200, "wrap");
    check_bursts("wrap", 2, 128, 128);
    if (rise_addr.size() > 1) check("wrap_addr1", rise_addr[1], 0);
    check("wrap_addr_after", wr_burst_addr, 128);

    // Stalled controller: FIFO fills, 44 words held back by the source
    clear_log();
    stall = 1;
    for (int i = 0; i < 300; i++) src.push_back(1000 + i);
    repeat (320) tick();
    check("full_level", fifo_level, 256);
    check("full_in_ready", in_ready, 0);
    check("full_pending", src.size(), 44);
    check("full_req", wr_burst_req, 1);
    check_bursts("full", 1, 128, 128);
    stall = 0;
    clear_log();
    run_until_quiet(1500, "drain");
    check("drain_level", fifo_level, 44);
    check("drain_nbursts", rise_addr.size(), 1);
    check("drain_addr_after", wr_burst_addr, 128);

    // Flush the 44 leftovers
    clear_log();
    flush_req = 1;
    run_until_quiet(400, "fl44");
    check_bursts("fl44", 1, 44, 128);
    check("fl44_addr_after", wr_burst_addr, 172);
    check("fl44_level", fifo_level, 0);

    // 5 words sit until flushed
    clear_log();
    for (int i = 0; i < 5; i++) src.push_back(50 + i);
    repeat (10) tick();
    check("f5_level_wait", fifo_level, 5);
    check("f5_no_req", wr_burst_req, 0);
    flush_req = 1;
    run_until_quiet(200, "f5");
    check_bursts("f5", 1, 5, 172);
    check("f5_addr_after", wr_burst_addr, 177);
    check("f5_busy_after", busy, 0);

    // Burst capped at region end: 256-177 = 79 words
    clear_log();
    for (int i = 0; i < 128; i++) src.push_back(2000 + i);
    run_until_quiet(600, "cap");
    check_bursts("cap", 1, 79, 177);
    check("cap_addr_after", wr_burst_addr, 0);
    check("cap_level", fifo_level, 49);

    // Random push/pop traffic with extra ignored data requests
    clear_log();
    ctrl_rand = 1; src_rand = 1; ctrl_extra = 2;
    for (int i = 0; i < 1000; i++) src.push_back(int'($urandom_range(0, 65535)));
    run_until_quiet(20000, "rand");
    flush_req = 1;
    run_until_quiet(3000, "rand_flush");
    check("rand_level", fifo_level, 0);
    check("rand_pushpop_seen", n_both > 0, 1);
    ctrl_rand = 0; src_rand = 0; ctrl_extra = 0;

    // Asynchronous reset in the middle of a burst
    clear_log();
    for (int i = 0; i < 128; i++) src.push_back(i + 7);
    hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      tick();
      hit = wr_burst_req && c_issued >= 3;
    end
    check("arst_wait", hit, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_req", wr_burst_req, 0);
    check("arst_len", wr_burst_len, 0);
    check("arst_addr", wr_burst_addr, BASE);
    check("arst_data", wr_burst_data, 0);
    check("arst_level", fifo_level, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_busy", busy, 0);
    model_reset();
    src.delete();
    repeat (2) tick();
    rst = 1'b0;
    clear_log();
    for (int i = 0; i < 128; i++) src.push_back(3000 + i);
    run_until_quiet(600, "post");
    check_bursts("post", 1, 128, BASE);
    check("post_addr_after", wr_burst_addr, 128);
    check("post_last_data", wr_burst_data, 3127);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_wr_burst_feeder.md
# sdram_wr_burst_feeder

Buffers a stream of 16-bit words in an on-chip FIFO and drains it into the SDRAM controller as fixed-length write bursts at incrementing, wrapping addresses. Sits directly upstream of `sdram_core`, on the write-burst port that `mem_test` drives in the memory test build. It runs on the same controller clock and produces `wr_burst_req/len/addr/data` exactly as the controller consumes them.

## Interface
- `MEM_DATA_BITS`, 16, data word width
- `ADDR_BITS`, 24, controller word address width
- `BURST_BITS`, 10, burst length field width
- `BURST_SIZE`, 128, words per full burst (≤ FIFO_DEPTH, < 2^BURST_BITS)
- `FIFO_DEPTH`, 256, buffer words (power of two)
- `BASE_ADDR`, 0, first word address of write region
- `REGION_WORDS`, 2^20, region size in words (multiple of BURST_SIZE)

Ports:
- `mem_clk` in 1 controller clock; everything on rising edge
- `rst` in 1 asynchronous, active-high reset
- `in_valid` in 1 input word valid
- `in_data` in MEM_DATA_BITS input word
- `in_ready` out 1 FIFO can accept
- `flush` in 1 single-cycle pulse: drain partial data
- `wr_burst_req` out 1 burst write request to controller
- `wr_burst_len` out BURST_BITS burst length in words
- `wr_burst_addr` out ADDR_BITS burst base word address
- `wr_burst_data_req` in 1 controller wants a word (data due next cycle)
- `wr_burst_data` out MEM_DATA_BITS write data
- `wr_burst_finish` in 1 controller burst complete pulse
- `fifo_level` out log2(FIFO_DEPTH)+1 words buffered
- `busy` out 1 burst in flight or flush pending
- `burst_cnt` out 32 completed bursts (only with WR_FEEDER_STATS_EN)

## Operation
- FIFO: push on `in_valid && in_ready`; `in_ready = fifo_level < FIFO_DEPTH`. Pop on `wr_burst_data_req` while in BURST with words remaining. Simultaneous push and pop leave the level unchanged.
- `flush` sets a sticky `flush_pend`. It clears when a burst that empties the FIFO is launched, or when the FIFO is empty and the FSM is idle.
- FSM states:
  - IDLE:
    - if `fifo_level >= BURST_SIZE`, latch len = BURST_SIZE and go to BURST;
    - else if `flush_pend && fifo_level > 0`, latch len = fifo_level and go to BURST.
    - In both cases, len is capped to the words remaining before region end, `BASE_ADDR+REGION_WORDS-addr`.
  - BURST:
    - `wr_burst_req` = 1; it is held until `wr_burst_finish`.
    - Each `wr_burst_data_req` pops one word while `sent < len`. Requests beyond len are ignored; the last data is held.
    - On `wr_burst_finish`, go to UPDATE.
  - UPDATE (1 cycle): addr += len; if the result ≥ BASE_ADDR+REGION_WORDS, addr = BASE_ADDR. `burst_cnt`++. Then go to IDLE.
- `len` is latched at launch. Words pushed during a burst are not part of it.
- Underflow is impossible by construction: len ≤ level at launch, and this block is the only popper.

## Timing
- Reset values:
  - `wr_burst_req` = 0
  - `wr_burst_len` = 0
  - `wr_burst_addr` = BASE_ADDR
  - `wr_burst_data` = 0
  - `fifo_level` = 0
  - `in_ready` = 1
  - `busy` = 0
  - `burst_cnt` = 0
  - `flush_pend` = 0
  - FIFO pointers = 0
  - FSM = IDLE
- Threshold reached at edge N → `wr_burst_req` high after edge N+1; `len`/`addr` are stable from then until finish.
- `wr_burst_data_req` high in cycle k → the popped word is on `wr_burst_data` in cycle k+1 (registered FIFO read). The first word is never late.
- Back-to-back bursts: minimum 2 idle cycles between `wr_burst_finish` and the next `wr_burst_req` (UPDATE, IDLE).
- Reset mid-burst drops `wr_burst_req` immediately and discards buffered data. The controller shares `rst`.

## Configuration
- `WR_FEEDER_STATS_EN`:
  - Defined: `burst_cnt` port and 32-bit counter exist. The counter increments in UPDATE and wraps at 2^32.
  - Undefined: the port and counter are absent; no other behaviour changes.

## Test plan
- Push 128 words 0..127 back-to-back; controller model asserts data_req 128 cycles → one burst, len=128, addr=0, data 0..127 in order, addr=128 afterwards, level 0.
- Push 300 words without draining (controller stalls req) → `in_ready` drops at level 256; words 256+ are not accepted; after drain, level=44 remains.
- Push 5 words, pulse `flush` → burst len=5 at current addr; next addr += 5; `flush_pend` clears; `busy` falls.
- REGION_WORDS=256, addr=128, push 256 words → bursts at 128 then 0 (wrap); third burst addr 128.
- Push and pop in the same cycle during a burst → level is unchanged that cycle; no word is lost or duplicated across 1000 random words.
- Assert `rst` mid-burst → `wr_burst_req`=0 asynchronously; all outputs at reset values; a new 128-word push then produces a correct burst at BASE_ADDR.
